// File: rtl/vram_arb_pkg.sv
// Shared types and helpers for the VRAM arbiter: address map constants,
// read-data source encoding and byte-lane helpers.
package vram_arb_pkg;

    localparam logic [18:0] REG_BASE_DEF = 19'h1F9C0;
    localparam logic [18:0] VRAM_TOP     = 19'h1FFFF;
    localparam int          STALL_W_DEF  = 16;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_VRAM = 2'd1,
        SRC_REG  = 2'd2
    } src_t;

    function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/vram_arb_stats.sv
// Saturating stall counter for the video fetch port; clear beats increment.
module vram_arb_stats #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: bus master has fixed priority with a one-cycle read
// latency, video fetch uses req/ack. Stall statistics built when VRAM_ARB_STATS_EN is defined.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter logic [18:0] REG_BASE = REG_BASE_DEF,
    parameter int          STALL_W  = STALL_W_DEF
) (
    input  logic               bm_clk,
    input  logic               bm_reset_n,
    input  logic [18:0]        bm_addr,
    input  logic [7:0]         bm_wrdata,
    input  logic               bm_strobe,
    input  logic               bm_write,
    output logic [7:0]         bm_rddata,
    input  logic               fetch_req,
    input  logic [14:0]        fetch_addr,
    output logic               fetch_ack,
    output logic               fetch_valid,
    output logic [31:0]        fetch_rddata,
    output logic [14:0]        ram_addr,
    output logic [31:0]        ram_wrdata,
    output logic [3:0]         ram_wrbytesel,
    output logic               ram_write,
    input  logic [31:0]        ram_rddata,
    output logic               reg_strobe,
    output logic               reg_write,
    output logic [10:0]        reg_addr,
    output logic [7:0]         reg_wrdata,
    input  logic [7:0]         reg_rddata,
    input  logic               stat_clr,
    output logic [STALL_W-1:0] stat_stall
);

    src_t        bm_src;
    logic        bm_vram;
    logic [18:0] reg_off;
    logic        rd_pend;
    src_t        rd_src;
    logic [1:0]  rd_lane;
    logic [7:0]  rd_hold;
    logic [7:0]  rd_live;

    // 0x20000..0x3FFFF lies above the register window and is treated like bit18 space.
    always_comb begin
        bm_src = SRC_NONE;
        if (bm_addr < REG_BASE) begin
            bm_src = SRC_VRAM;
        end else if (bm_addr <= VRAM_TOP) begin
            bm_src = SRC_REG;
        end
    end

    assign bm_vram       = bm_strobe && (bm_src == SRC_VRAM);
    assign fetch_ack     = fetch_req && !bm_vram;
    assign ram_addr      = bm_vram ? bm_addr[16:2] : fetch_addr;
    assign ram_write     = bm_vram && bm_write;
    assign ram_wrdata    = {4{bm_wrdata}};
    assign ram_wrbytesel = ram_write ? lane_onehot(bm_addr[1:0]) : 4'b0000;

    assign reg_off    = bm_addr - REG_BASE;
    assign reg_strobe = bm_strobe && (bm_src == SRC_REG);
    assign reg_write  = reg_strobe && bm_write;
    assign reg_addr   = reg_off[10:0];
    assign reg_wrdata = bm_wrdata;

    // Source and lane of a read are latched at the strobe; the byte is captured
    // from the live bus one cycle later and then held until the next read.
    always_ff @(posedge bm_clk or negedge bm_reset_n) begin
        if (!bm_reset_n) begin
            rd_pend     <= 1'b0;
            rd_src      <= SRC_NONE;
            rd_lane     <= 2'd0;
            rd_hold     <= 8'h00;
            fetch_valid <= 1'b0;
        end else begin
            rd_pend     <= bm_strobe && !bm_write;
            fetch_valid <= fetch_ack;
            if (bm_strobe && !bm_write) begin
                rd_src  <= bm_src;
                rd_lane <= bm_addr[1:0];
            end
            if (rd_pend) begin
                rd_hold <= rd_live;
            end
        end
    end

    always_comb begin
        rd_live = 8'h00;
        case (rd_src)
            SRC_VRAM: rd_live = lane_sel(ram_rddata, rd_lane);
            SRC_REG:  rd_live = reg_rddata;
            default:  rd_live = 8'h00;
        endcase
    end

    assign bm_rddata    = rd_pend ? rd_live : rd_hold;
    assign fetch_rddata = ram_rddata;

`ifdef VRAM_ARB_STATS_EN
    logic unused_reg_off_hi;
    assign unused_reg_off_hi = ^reg_off[18:11];

    vram_arb_stats #(
        .W(STALL_W)
    ) u_stats (
        .clk   (bm_clk),
        .rst_n (bm_reset_n),
        .clr   (stat_clr),
        .inc   (fetch_req && !fetch_ack),
        .count (stat_stall)
    );
`else
    logic unused_bits;
    assign unused_bits = ^{stat_clr, reg_off[18:11]};
    assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: byte-addressed reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_vram_arbiter;

    localparam int REG_BASE = 'h1F9C0;
    localparam int STALL_MAX = 65535;
`ifdef VRAM_ARB_STATS_EN
    localparam int EXP_STALL5 = 2;
`else
    localparam int EXP_STALL5 = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic [18:0] bm_addr;
    logic [7:0]  bm_wrdata;
    logic        bm_strobe;
    logic        bm_write;
    logic [7:0]  bm_rddata;
    logic        fetch_req;
    logic [14:0] fetch_addr;
    logic        fetch_ack;
    logic        fetch_valid;
    logic [31:0] fetch_rddata;
    logic [14:0] ram_addr;
    logic [31:0] ram_wrdata;
    logic [3:0]  ram_wrbytesel;
    logic        ram_write;
    logic [31:0] ram_rddata;
    logic        reg_strobe;
    logic        reg_write;
    logic [10:0] reg_addr;
    logic [7:0]  reg_wrdata;
    logic [7:0]  reg_rddata;
    logic        stat_clr;
    logic [15:0] stat_stall;

    int n_vec;
    int n_err;

    vram_arbiter dut (
        .bm_clk        (clk),
        .bm_reset_n    (rst_n),
        .bm_addr       (bm_addr),
        .bm_wrdata     (bm_wrdata),
        .bm_strobe     (bm_strobe),
        .bm_write      (bm_write),
        .bm_rddata     (bm_rddata),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_ack     (fetch_ack),
        .fetch_valid   (fetch_valid),
        .fetch_rddata  (fetch_rddata),
        .ram_addr      (ram_addr),
        .ram_wrdata    (ram_wrdata),
        .ram_wrbytesel (ram_wrbytesel),
        .ram_write     (ram_write),
        .ram_rddata    (ram_rddata),
        .reg_strobe    (reg_strobe),
        .reg_write     (reg_write),
        .reg_addr      (reg_addr),
        .reg_wrdata    (reg_wrdata),
        .reg_rddata    (reg_rddata),
        .stat_clr      (stat_clr),
        .stat_stall    (stat_stall)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM device: 32-bit words, byte-enabled writes, one-cycle read latency.
    logic [31:0] mem [32768];
    always @(posedge clk) begin
        if (ram_write) begin
            for (int l = 0; l < 4; l++) begin
                if (ram_wrbytesel[l]) mem[ram_addr][8*l +: 8] <= ram_wrdata[8*l +: 8];
            end
        end
        ram_rddata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a flat byte array for VRAM plus the observable pipeline state.
    logic [7:0] vmem [131072];
    int         m_rd;
    bit         m_rd_pend;
    int         m_rd_src;     // 0 none, 1 vram, 2 reg
    int         m_rd_byte;
    bit         m_fv;
    logic [31:0] m_fword;
    int         m_stall;

    function automatic logic [31:0] vword(input int w);
        return {vmem[4*w+3], vmem[4*w+2], vmem[4*w+1], vmem[4*w]};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_rd = 0; m_rd_pend = 0; m_rd_src = 0; m_rd_byte = 0;
            m_fv = 0; m_fword = 0; m_stall = 0;
        end else begin
            int a;
            bit is_vram;
            bit is_reg;
            bit bm_vr;
            bit ack;
            a       = int'(bm_addr);
            is_vram = a < REG_BASE;
            is_reg  = !is_vram && a <= 'h1FFFF;
            bm_vr   = bm_strobe && is_vram;
            ack     = fetch_req && !bm_vr;

            chk("fetch_ack", {31'd0, fetch_ack}, {31'd0, ack});
            chk("ram_write", {31'd0, ram_write}, {31'd0, bm_vr && bm_write});
            chk("reg_strobe", {31'd0, reg_strobe}, {31'd0, bm_strobe && is_reg});
            if (bm_vr) begin
                chk("ram_addr_bm", {17'd0, ram_addr}, a / 4);
                if (bm_write) begin
                    chk("ram_wrbytesel", {28'd0, ram_wrbytesel}, 32'd1 << (a % 4));
                    chk("ram_wrdata", ram_wrdata, {4{bm_wrdata}});
                end
            end else if (ack) begin
                chk("ram_addr_fetch", {17'd0, ram_addr}, {17'd0, fetch_addr});
            end
            if (bm_strobe && is_reg) begin
                chk("reg_addr", {21'd0, reg_addr}, a - REG_BASE);
                chk("reg_write", {31'd0, reg_write}, {31'd0, bm_write});
                chk("reg_wrdata", {24'd0, reg_wrdata}, {24'd0, bm_wrdata});
            end
            chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_fv});
            if (m_fv) chk("fetch_rddata", fetch_rddata, m_fword);
            if (m_rd_pend) begin
                m_rd = (m_rd_src == 1) ? m_rd_byte : (m_rd_src == 2) ? int'(reg_rddata) : 0;
            end
            chk("bm_rddata", {24'd0, bm_rddata}, m_rd);
            chk("stat_stall", {16'd0, stat_stall}, m_stall);

            // Effects of the coming edge.
            m_fv = ack;
            if (ack) m_fword = vword(int'(fetch_addr));
            m_rd_pend = bm_strobe && !bm_write;
            if (m_rd_pend) begin
                m_rd_src  = is_vram ? 1 : is_reg ? 2 : 0;
                m_rd_byte = is_vram ? int'(vmem[a]) : 0;
            end
            if (bm_vr && bm_write) vmem[a] = bm_wrdata;
`ifdef VRAM_ARB_STATS_EN
            if (stat_clr) m_stall = 0;
            else if (fetch_req && !ack && m_stall < STALL_MAX) m_stall++;
`endif
        end
    end

    // Driver tasks: inputs change at posedge+1, literal checks at negedge+1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bm_strobe = 0; bm_write = 0; fetch_req = 0; stat_clr = 0;
    endtask

    task automatic bm(input logic [18:0] addr, input logic wr, input logic [7:0] d);
        bm_strobe = 1; bm_write = wr; bm_addr = addr; bm_wrdata = d;
    endtask

    int n_ack;

    initial begin
        n_vec = 0; n_err = 0;
        for (int i = 0; i < 32768; i++) mem[i] = '0;
        for (int i = 0; i < 131072; i++) vmem[i] = '0;
        rst_n = 0; bm_addr = '0; bm_wrdata = '0; fetch_addr = '0; reg_rddata = '0;
        idle();
        mid();
        chk("reset_bm_rddata", {24'd0, bm_rddata}, 32'h0);
        chk("reset_fetch_valid", {31'd0, fetch_valid}, 32'h0);
        chk("reset_stat_stall", {16'd0, stat_stall}, 32'h0);
        tick(); tick();
        rst_n = 1;
        tick();

        // 1: byte write then read back through lane 3
        bm(19'h00003, 1, 8'hA5);
        mid();
        chk("t1_wrbytesel", {28'd0, ram_wrbytesel}, 32'h8);
        chk("t1_ram_write", {31'd0, ram_write}, 32'h1);
        tick();
        bm(19'h00003, 0, 8'h00);
        mid();
        chk("t1_rd_ram_write", {31'd0, ram_write}, 32'h0);
        tick();
        idle();
        mid();
        chk("t1_bm_rddata", {24'd0, bm_rddata}, 32'hA5);
        tick();

        // 2: bm write and fetch same cycle; fetch deferred and sees the written byte
        bm(19'h00041, 1, 8'h5A);
        fetch_req = 1; fetch_addr = 15'h0010;
        mid();
        chk("t2_ack_blocked", {31'd0, fetch_ack}, 32'h0);
        tick();
        bm_strobe = 0; bm_write = 0;
        mid();
        chk("t2_ack", {31'd0, fetch_ack}, 32'h1);
        chk("t2_ram_addr", {17'd0, ram_addr}, 32'h10);
        tick();
        idle();
        mid();
        chk("t2_fetch_valid", {31'd0, fetch_valid}, 32'h1);
        chk("t2_fetch_rddata", fetch_rddata, 32'h00005A00);
        chk("t2_bm_rddata_kept", {24'd0, bm_rddata}, 32'hA5);
        tick();
        mid();
        chk("t2_fetch_valid_1cyc", {31'd0, fetch_valid}, 32'h0);
        tick();

        // 3: register read with concurrent fetch; window boundaries
        bm(19'h1F9C0, 0, 8'h00);
        reg_rddata = 8'h3C; fetch_req = 1; fetch_addr = 15'h0020;
        mid();
        chk("t3_reg_strobe", {31'd0, reg_strobe}, 32'h1);
        chk("t3_reg_addr", {21'd0, reg_addr}, 32'h0);
        chk("t3_ack", {31'd0, fetch_ack}, 32'h1);
        tick();
        idle();
        mid();
        chk("t3_bm_rddata", {24'd0, bm_rddata}, 32'h3C);
        tick();
        reg_rddata = 8'h77;
        mid();
        chk("t3_hold", {24'd0, bm_rddata}, 32'h3C);
        tick();
        bm(19'h1FFFF, 1, 8'h11);
        mid();
        chk("t3_top_reg_addr", {21'd0, reg_addr}, 32'h63F);
        chk("t3_top_reg_write", {31'd0, reg_write}, 32'h1);
        tick();
        bm(19'h1F9BF, 0, 8'h00);
        mid();
        chk("t3_below_reg_strobe", {31'd0, reg_strobe}, 32'h0);
        chk("t3_below_ram_addr", {17'd0, ram_addr}, 32'h7E6F);
        tick();
        idle();
        tick();

        // 4: unmapped space
        bm(19'h40000, 0, 8'h00);
        mid();
        chk("t4_rd_reg_strobe", {31'd0, reg_strobe}, 32'h0);
        chk("t4_rd_ram_write", {31'd0, ram_write}, 32'h0);
        tick();
        bm(19'h40000, 1, 8'hFF);
        fetch_req = 1; fetch_addr = 15'h0000;
        mid();
        chk("t4_bm_rddata", {24'd0, bm_rddata}, 32'h0);
        chk("t4_wr_ram_write", {31'd0, ram_write}, 32'h0);
        chk("t4_wr_reg_strobe", {31'd0, reg_strobe}, 32'h0);
        chk("t4_wr_ack", {31'd0, fetch_ack}, 32'h1);
        tick();
        idle();
        tick();

        // Back-to-back grants on consecutive words
        for (int i = 0; i < 3; i++) begin
            fetch_req = 1; fetch_addr = 15'(i);
            mid();
            chk("b2b_ack", {31'd0, fetch_ack}, 32'h1);
            tick();
        end
        idle();
        tick();

        // 5: four cycles of fetch_req, bm strobes on alternating cycles
        stat_clr = 1;
        tick();
        stat_clr = 0;
        n_ack = 0;
        for (int i = 0; i < 4; i++) begin
            fetch_req = 1; fetch_addr = 15'h0030;
            if (i % 2 == 0) bm(19'h00100 + 19'(i), 0, 8'h00);
            else begin bm_strobe = 0; bm_write = 0; end
            mid();
            n_ack += int'(fetch_ack);
            tick();
        end
        idle();
        mid();
        chk("t5_acks", n_ack, 2);
        chk("t5_stat_stall", {16'd0, stat_stall}, EXP_STALL5);
        tick();

        // 6: asynchronous reset while fetch_valid is high
        bm(19'h1F9C0, 0, 8'h00);
        reg_rddata = 8'h3C; fetch_req = 1; fetch_addr = 15'h0010;
        tick();
        idle();
        mid();
        chk("t6_pre_fetch_valid", {31'd0, fetch_valid}, 32'h1);
        chk("t6_pre_bm_rddata", {24'd0, bm_rddata}, 32'h3C);
        rst_n = 0;
        #1;
        chk("t6_fetch_valid", {31'd0, fetch_valid}, 32'h0);
        chk("t6_bm_rddata", {24'd0, bm_rddata}, 32'h0);
        chk("t6_stat_stall", {16'd0, stat_stall}, 32'h0);
        tick(); tick();
        rst_n = 1;
        tick();
        mid();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
